// File: rtl/decode_stage_if.sv
// Signals between IF/ID, the register file, writeback and the ID/EX consumer.
// master = decode stage, slave = surrounding pipeline.
interface decode_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic [31:0]               instr_d_i;
    logic [DATA_WIDTH-1:0]     pc_d_i;
    logic [DATA_WIDTH-1:0]     pc_plus4_d_i;
    logic                      valid_d_i;
    logic                      stall_e_i;
    logic                      flush_e_i;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_o;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_o;
    logic [DATA_WIDTH-1:0]     rs1_data_i;
    logic [DATA_WIDTH-1:0]     rs2_data_i;
    logic                      rd_write_en_wb_i;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_wb_i;
    logic [DATA_WIDTH-1:0]     rd_data_wb_i;
    logic                      valid_e_o;
    logic                      reg_write_e_o;
    logic [1:0]                result_src_e_o;
    logic                      mem_write_e_o;
    logic                      branch_e_o;
    logic                      jump_e_o;
    logic                      jalr_e_o;
    logic                      alu_src_a_e_o;
    logic                      alu_src_b_e_o;
    logic [3:0]                alu_control_e_o;
    logic [2:0]                funct3_e_o;
    logic [DATA_WIDTH-1:0]     rs1_data_e_o;
    logic [DATA_WIDTH-1:0]     rs2_data_e_o;
    logic [DATA_WIDTH-1:0]     imm_ext_e_o;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_e_o;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_e_o;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_e_o;
    logic [DATA_WIDTH-1:0]     pc_e_o;
    logic [DATA_WIDTH-1:0]     pc_plus4_e_o;
    logic                      illegal_e_o;

    modport master (
        input  instr_d_i, pc_d_i, pc_plus4_d_i, valid_d_i, stall_e_i, flush_e_i,
               rs1_data_i, rs2_data_i, rd_write_en_wb_i, rd_addr_wb_i, rd_data_wb_i,
        output rs1_addr_o, rs2_addr_o, valid_e_o, reg_write_e_o, result_src_e_o,
               mem_write_e_o, branch_e_o, jump_e_o, jalr_e_o, alu_src_a_e_o, alu_src_b_e_o,
               alu_control_e_o, funct3_e_o, rs1_data_e_o, rs2_data_e_o, imm_ext_e_o,
               rs1_addr_e_o, rs2_addr_e_o, rd_addr_e_o, pc_e_o, pc_plus4_e_o, illegal_e_o
    );

    modport slave (
        output instr_d_i, pc_d_i, pc_plus4_d_i, valid_d_i, stall_e_i, flush_e_i,
               rs1_data_i, rs2_data_i, rd_write_en_wb_i, rd_addr_wb_i, rd_data_wb_i,
        input  rs1_addr_o, rs2_addr_o, valid_e_o, reg_write_e_o, result_src_e_o,
               mem_write_e_o, branch_e_o, jump_e_o, jalr_e_o, alu_src_a_e_o, alu_src_b_e_o,
               alu_control_e_o, funct3_e_o, rs1_data_e_o, rs2_data_e_o, imm_ext_e_o,
               rs1_addr_e_o, rs2_addr_e_o, rd_addr_e_o, pc_e_o, pc_plus4_e_o, illegal_e_o
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode: RF address drive, WB->ID bypass, control/immediate decode, ID/EX register.
// One cycle instr_d_i -> *_e_o; stall_e_i holds ID/EX, flush_e_i (wins over stall) loads a bubble.
module decode_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    decode_stage_if.master io
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    typedef struct packed {
        logic                      valid;
        logic                      reg_write;
        logic [1:0]                result_src;
        logic                      mem_write;
        logic                      branch;
        logic                      jump;
        logic                      jalr;
        logic                      alu_src_a;
        logic                      alu_src_b;
        logic [3:0]                alu_control;
        logic [2:0]                funct3;
        logic [DATA_WIDTH-1:0]     rs1_data;
        logic [DATA_WIDTH-1:0]     rs2_data;
        logic [DATA_WIDTH-1:0]     imm;
        logic [REG_ADDR_WIDTH-1:0] rs1_addr;
        logic [REG_ADDR_WIDTH-1:0] rs2_addr;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic [DATA_WIDTH-1:0]     pc;
        logic [DATA_WIDTH-1:0]     pc_plus4;
        logic                      illegal;
    } idex_t;

    idex_t                     dec;
    idex_t                     idex_d;
    idex_t                     idex_q;
    logic [31:0]               instr;
    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [DATA_WIDTH-1:0]     rs1_fwd;
    logic [DATA_WIDTH-1:0]     rs2_fwd;
    logic [31:0]               imm32;
    logic [3:0]                alu_f3;

    assign instr         = io.instr_d_i;
    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign rs1_addr      = REG_ADDR_WIDTH'(instr[19:15]);
    assign rs2_addr      = REG_ADDR_WIDTH'(instr[24:20]);
    assign io.rs1_addr_o = rs1_addr;
    assign io.rs2_addr_o = rs2_addr;

    // RF write lands on the same edge that ID/EX captures, so the WB value must be taken here.
    always_comb begin
        rs1_fwd = io.rs1_data_i;
        if (rs1_addr == '0)
            rs1_fwd = '0;
        else if (io.rd_write_en_wb_i && io.rd_addr_wb_i == rs1_addr)
            rs1_fwd = io.rd_data_wb_i;
        rs2_fwd = io.rs2_data_i;
        if (rs2_addr == '0)
            rs2_fwd = '0;
        else if (io.rd_write_en_wb_i && io.rd_addr_wb_i == rs2_addr)
            rs2_fwd = io.rd_data_wb_i;
    end

    always_comb begin
        imm32 = '0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:                 imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         imm32 = {instr[31:12], 12'b0};
            OP_JAL: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:                  imm32 = '0;
        endcase
    end

    always_comb begin
        alu_f3 = ALU_ADD;
        case (funct3)
            3'b000:  alu_f3 = ALU_ADD;
            3'b001:  alu_f3 = ALU_SLL;
            3'b010:  alu_f3 = ALU_SLT;
            3'b011:  alu_f3 = ALU_SLTU;
            3'b100:  alu_f3 = ALU_XOR;
            3'b101:  alu_f3 = ALU_SRL;
            3'b110:  alu_f3 = ALU_OR;
            default: alu_f3 = ALU_AND;
        endcase
    end

    always_comb begin
        dec          = '0;
        dec.valid    = io.valid_d_i;
        dec.funct3   = funct3;
        dec.rs1_data = rs1_fwd;
        dec.rs2_data = rs2_fwd;
        dec.imm      = DATA_WIDTH'($signed(imm32));
        dec.rs1_addr = rs1_addr;
        dec.rs2_addr = rs2_addr;
        dec.rd_addr  = REG_ADDR_WIDTH'(instr[11:7]);
        dec.pc       = io.pc_d_i;
        dec.pc_plus4 = io.pc_plus4_d_i;
        case (opcode)
            OP_R: begin
                if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                    dec.reg_write   = 1'b1;
                    dec.alu_control = alu_f3;
                    if (funct7[5] && funct3 == 3'b000) dec.alu_control = ALU_SUB;
                    if (funct7[5] && funct3 == 3'b101) dec.alu_control = ALU_SRA;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_IMM: begin
                dec.reg_write   = 1'b1;
                dec.alu_src_b   = 1'b1;
                dec.alu_control = (funct3 == 3'b101 && funct7[5]) ? ALU_SRA : alu_f3;
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src_b  = 1'b1;
                dec.result_src = 2'b01;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src_b = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch      = 1'b1;
                dec.alu_control = ALU_SUB;
            end
            OP_LUI: begin
                // Zeroing the index too stops EX forwarding from replacing the forced-zero operand.
                dec.reg_write = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.rs1_data  = '0;
                dec.rs1_addr  = '0;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = 1'b1;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = 2'b10;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.jalr       = 1'b1;
                dec.result_src = 2'b10;
                dec.alu_src_b  = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (!io.valid_d_i) begin
            dec.reg_write = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
            dec.jalr      = 1'b0;
            dec.illegal   = 1'b0;
        end
    end

    always_comb begin
        idex_d = dec;
        if (io.flush_e_i)
            idex_d = '0;
        else if (io.stall_e_i)
            idex_d = idex_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idex_q <= '0;
        else        idex_q <= idex_d;
    end

    assign io.valid_e_o       = idex_q.valid;
    assign io.reg_write_e_o   = idex_q.reg_write;
    assign io.result_src_e_o  = idex_q.result_src;
    assign io.mem_write_e_o   = idex_q.mem_write;
    assign io.branch_e_o      = idex_q.branch;
    assign io.jump_e_o        = idex_q.jump;
    assign io.jalr_e_o        = idex_q.jalr;
    assign io.alu_src_a_e_o   = idex_q.alu_src_a;
    assign io.alu_src_b_e_o   = idex_q.alu_src_b;
    assign io.alu_control_e_o = idex_q.alu_control;
    assign io.funct3_e_o      = idex_q.funct3;
    assign io.rs1_data_e_o    = idex_q.rs1_data;
    assign io.rs2_data_e_o    = idex_q.rs2_data;
    assign io.imm_ext_e_o     = idex_q.imm;
    assign io.rs1_addr_e_o    = idex_q.rs1_addr;
    assign io.rs2_addr_e_o    = idex_q.rs2_addr;
    assign io.rd_addr_e_o     = idex_q.rd_addr;
    assign io.pc_e_o          = idex_q.pc;
    assign io.pc_plus4_e_o    = idex_q.pc_plus4;
    assign io.illegal_e_o     = idex_q.illegal;
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode (ID) stage of the 5-stage RV32I pipeline.
- Inputs: the IF/ID instruction. It drives the register-file read addresses and decodes control signals and the sign-extended immediate.
- Applies a writeback-to-decode bypass, because the register file writes on the clock edge while reads are asynchronous.
- Captures everything in the ID/EX pipeline register, with stall and flush, for the execute stage.

Parameters:
- DATA_WIDTH, 32, datapath/XLEN width
- REG_ADDR_WIDTH, 5, register index width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- instr_d_i  in  32  instruction from IF/ID
- pc_d_i  in  DATA_WIDTH  PC of instr_d_i
- pc_plus4_d_i  in  DATA_WIDTH  PC+4 of instr_d_i
- valid_d_i  in  1  IF/ID slot holds a real instruction
- stall_e_i  in  1  hold the ID/EX register
- flush_e_i  in  1  load a bubble into ID/EX
- rs1_addr_o  out  REG_ADDR_WIDTH  RF read port 1 address (combinational, instr[19:15])
- rs2_addr_o  out  REG_ADDR_WIDTH  RF read port 2 address (instr[24:20])
- rs1_data_i  in  DATA_WIDTH  RF read data 1
- rs2_data_i  in  DATA_WIDTH  RF read data 2
- rd_write_en_wb_i  in  1  WB write enable (RegWriteW)
- rd_addr_wb_i  in  REG_ADDR_WIDTH  WB destination (RdW)
- rd_data_wb_i  in  DATA_WIDTH  WB data (ResultW)
- valid_e_o  out  1  ID/EX holds a real instruction
- reg_write_e_o  out  1  instruction writes rd
- result_src_e_o  out  2  00 ALU, 01 load data, 10 PC+4
- mem_write_e_o  out  1  store
- branch_e_o  out  1  conditional branch
- jump_e_o  out  1  JAL/JALR
- jalr_e_o  out  1  target = rs1+imm
- alu_src_a_e_o  out  1  0 rs1, 1 PC
- alu_src_b_e_o  out  1  0 rs2, 1 immediate
- alu_control_e_o  out  4  ALU operation
- funct3_e_o  out  3  instr[14:12]; branch condition and load/store size
- rs1_data_e_o  out  DATA_WIDTH  operand 1
- rs2_data_e_o  out  DATA_WIDTH  operand 2
- imm_ext_e_o  out  DATA_WIDTH  sign-extended immediate
- rs1_addr_e_o  out  REG_ADDR_WIDTH  source 1 index, for forwarding
- rs2_addr_e_o  out  REG_ADDR_WIDTH  source 2 index, for forwarding
- rd_addr_e_o  out  REG_ADDR_WIDTH  destination index
- pc_e_o  out  DATA_WIDTH  PC
- pc_plus4_e_o  out  DATA_WIDTH  PC+4
- illegal_e_o  out  1  unsupported opcode/funct

Behaviour:
- Reset (async, rst_n low): every *_e_o output goes to 0 immediately and stays 0 until the first enabled clock edge after release.

Bypass (combinational):
- For each source n: if rd_write_en_wb_i && rd_addr_wb_i!=0 && rd_addr_wb_i==rsn_addr_o, then operand n = rd_data_wb_i, else rsn_data_i.
- rs index 0 always yields 0.

Immediate, by opcode:
- I-type (0010011, 0000011, 1100111): instr[31:20]
- S-type (0100011): {instr[31:25], instr[11:7]}
- B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- U-type (0110111, 0010111): {instr[31:12], 12'b0}
- J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- Sign-extend all immediates to DATA_WIDTH. Other opcodes give 0.

ALU encoding:
- 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA

Decode per opcode:
- R-type: funct7[5]=1 selects SUB or SRA.
- OP-IMM: SRAI requires funct7[5]=1; ADDI never decodes to SUB.
- Loads and stores: ADD.
- Branch: SUB, branch=1.
- LUI: ADD, alu_src_b=1, operand 1 forced to 0.
- AUIPC: ADD, alu_src_a=1, alu_src_b=1.
- JAL: jump=1, result_src=10.
- JALR: jump=1, jalr=1, result_src=10, ADD, alu_src_b=1.
- Illegal (unknown opcode, or R-type funct7 not in {0000000, 0100000}): all control outputs 0 (NOP), illegal=1.

ID/EX update rule at posedge clk, in priority order:
- flush_e_i: bubble. valid, reg_write, mem_write, branch, jump, jalr and illegal go to 0. Datapath fields are don't-care; drive them to 0.
- else stall_e_i: hold all fields.
- else: load decoded values. valid_e_o = valid_d_i.
- When valid_d_i=0, reg_write, mem_write, branch, jump, jalr and illegal are also loaded as 0.

Latency and boundaries:
- One cycle from instr_d_i to the *_e_o outputs.
- RF addresses are purely combinational; the bypass is purely combinational.
- Simultaneous flush and stall: flush wins.
- Reset asserted mid-stall clears everything.

Test Plan:
- Reset asserted with outputs mid-value → all *_e_o = 0 asynchronously. After release, addi x1,x0,5 (0x00500093) → next cycle reg_write=1, alu_src_b=1, ALU=0000, imm=5, rd=1.
- add 0x002081B3 vs sub 0x402081B3, with rs1_data_i=7 and rs2_data_i=3 → ALU 0000 vs 0001; operands 7/3; rd=3.
- lw x5,8(x2) 0x00812283 → result_src=01, imm=8. sw x5,12(x2) 0x00512623 → mem_write=1, reg_write=0, imm=12. beq 0xFE208EE3 → branch=1, imm=0xFFFFFFFC.
- Bypass: instr reads x1 while WB writes x1=0xDEADBEEF and RF returns stale 0 → rs1_data_e_o=0xDEADBEEF. The same case with rd_addr_wb_i=0, or with write enable low, gives no bypass.
- stall_e_i held 2 cycles while instr_d_i changes → outputs unchanged. flush_e_i with stall_e_i both high → valid_e_o=0, reg_write=0.
- Opcode 0x7F (0x0000007F) with valid_d_i=1 → illegal_e_o=1 and all control 0. valid_d_i=0 with a legal add → valid=0, reg_write=0.
